// File: rtl/vga_scan.sv
// Parametrised VGA timing generator with frame-buffer scan-out.
// Optional colour-bar test pattern: define VGA_SCAN_TESTPAT_EN.
module vga_scan #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CNT_W    = 10,
  parameter int ADDR_W   = 19,
  parameter int COLOR_W  = 4,
  parameter int RD_LAT   = 1,
  parameter int SCALE    = 1
) (
  input  logic                 clk25,
  input  logic                 reset,
  output logic [ADDR_W-1:0]    frame_addr,
  input  logic [3*COLOR_W-1:0] frame_pixel,
  output logic [COLOR_W-1:0]   vga_red,
  output logic [COLOR_W-1:0]   vga_green,
  output logic [COLOR_W-1:0]   vga_blue,
  output logic                 vga_hsync,
  output logic                 vga_vsync,
  output logic                 vga_blank,
  output logic                 frame_start
`ifdef VGA_SCAN_TESTPAT_EN
  ,
  input  logic                 test_en
`endif
);

  localparam int H_TOTAL =
    H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL =
    V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int BUF_W = H_ACTIVE / SCALE;
  localparam int BUF_H =
    (V_ACTIVE + SCALE - 1) / SCALE;
  localparam longint BUF_SIZE =
    longint'(BUF_W) * longint'(BUF_H);
  localparam longint CNT_MAX =
    longint'(1) << CNT_W;
  localparam longint ADDR_MAX =
    longint'(1) << ADDR_W;

  localparam logic [CNT_W-1:0] H_LAST =
    CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST =
    CNT_W'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP =
    ADDR_W'(BUF_W);
  localparam logic HS_ACT = 1'(HS_POL);
  localparam logic VS_ACT = 1'(VS_POL);

  if (longint'(H_TOTAL) > CNT_MAX) begin : g_bad_h
    $error("H_TOTAL exceeds counter range");
  end
  if (longint'(V_TOTAL) > CNT_MAX) begin : g_bad_v
    $error("V_TOTAL exceeds counter range");
  end
  if (BUF_SIZE > ADDR_MAX) begin : g_bad_a
    $error("frame buffer exceeds address range");
  end
  if (RD_LAT < 0 || RD_LAT > 4) begin : g_bad_l
    $error("RD_LAT must be 0..4");
  end
  if (SCALE != 1 && SCALE != 2) begin : g_bad_s
    $error("SCALE must be 1 or 2");
  end

  typedef struct packed {
    logic act;
    logic hs;
    logic vs;
    logic first;
  } tag_t;

  logic [CNT_W-1:0]  h;
  logic [CNT_W-1:0]  v;
  logic [CNT_W-1:0]  h_buf;
  logic [ADDR_W-1:0] row_base;
  int                h_i;
  int                v_i;
  logic              active0;
  logic              hs0;
  logic              vs0;
  logic              first0;
  tag_t              tag0;
  tag_t              tag_o;
  tag_t              pipe [RD_LAT+1];
  logic [3*COLOR_W-1:0] pix;

  assign h_i = int'(h);
  assign v_i = int'(v);

  assign active0 = (h_i < H_ACTIVE) &&
                   (v_i < V_ACTIVE);
  assign hs0 = (h_i >= H_ACTIVE + H_FP) &&
    (h_i < H_ACTIVE + H_FP + H_SYNC);
  assign vs0 = (v_i >= V_ACTIVE + V_FP) &&
    (v_i < V_ACTIVE + V_FP + V_SYNC);
  assign first0 = (h == '0) && (v == '0);
  assign tag0 = {active0, hs0, vs0, first0};
  assign h_buf = (SCALE == 2) ? (h >> 1) : h;
  assign tag_o = pipe[RD_LAT];

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      if (v == V_LAST) v <= '0;
      else v <= v + CNT_W'(1);
    end else begin
      h <= h + CNT_W'(1);
    end
  end

  // With SCALE=2 each buffer row is scanned on two lines,
  // so the base only steps after odd lines.
  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      row_base <= '0;
    end else if (h == H_LAST) begin
      if (v == V_LAST)
        row_base <= '0;
      else if (v_i < V_ACTIVE &&
               (SCALE == 1 || v[0]))
        row_base <= row_base + ROW_STEP;
    end
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset)
      frame_addr <= '0;
    else if (active0)
      frame_addr <= row_base + ADDR_W'(h_buf);
    else
      frame_addr <= '0;
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= RD_LAT; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= tag0;
      for (int i = 1; i <= RD_LAT; i++)
        pipe[i] <= pipe[i-1];
    end
  end

`ifdef VGA_SCAN_TESTPAT_EN
  logic [2:0] bar0;
  logic [2:0] bar_o;
  logic [2:0] bar_pipe [RD_LAT+1];

  // Bar b = h*8/H_ACTIVE, as threshold compares.
  always_comb begin
    bar0 = '0;
    for (int k = 1; k < 8; k++)
      if (h_i * 8 >= k * H_ACTIVE)
        bar0 = 3'(k);
  end

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= RD_LAT; i++)
        bar_pipe[i] <= '0;
    end else begin
      bar_pipe[0] <= bar0;
      for (int i = 1; i <= RD_LAT; i++)
        bar_pipe[i] <= bar_pipe[i-1];
    end
  end

  assign bar_o = bar_pipe[RD_LAT];

  always_comb begin
    pix = frame_pixel;
    if (test_en)
      pix = {{COLOR_W{bar_o[2]}},
             {COLOR_W{bar_o[1]}},
             {COLOR_W{bar_o[0]}}};
  end
`else
  always_comb begin
    pix = frame_pixel;
  end
`endif

  always_ff @(posedge clk25 or posedge reset) begin
    if (reset) begin
      vga_red     <= '0;
      vga_green   <= '0;
      vga_blue    <= '0;
      vga_hsync   <= ~HS_ACT;
      vga_vsync   <= ~VS_ACT;
      vga_blank   <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      if (tag_o.act)
        {vga_red, vga_green, vga_blue} <= pix;
      else
        {vga_red, vga_green, vga_blue} <= '0;
      vga_hsync   <= tag_o.hs ? HS_ACT : ~HS_ACT;
      vga_vsync   <= tag_o.vs ? VS_ACT : ~VS_ACT;
      vga_blank   <= ~tag_o.act;
      frame_start <= tag_o.first;
    end
  end

endmodule
